// File: rtl/hangman_pkg.sv
// Shared defaults, state encoding and constants for the hangman datapath.
package hangman_pkg;

  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_CHAR_W  = 8;
  localparam int DEF_CNT_W   = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_SCAN = S_SCAN,
    ST_DONE = S_DONE
  } state_e;

  localparam logic [DEF_CHAR_W-1:0] BLANK_CHAR = 8'h00;

endpackage

// File: rtl/hangman_word_store.sv
// Secret-word register file: one write port, two combinational read ports
// (scan index and display address). Out-of-range reads return BLANK_CHAR.
module hangman_word_store
  import hangman_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CHAR_W  = DEF_CHAR_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [CNT_W-1:0]  waddr_i,
  input  logic [CHAR_W-1:0] wdata_i,
  input  logic [CNT_W-1:0]  raddr_a_i,
  output logic [CHAR_W-1:0] rdata_a_o,
  input  logic [CNT_W-1:0]  raddr_b_i,
  output logic [CHAR_W-1:0] rdata_b_o
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [CHAR_W-1:0] mem_q [MAX_LEN];

  // Contents need no reset: the datapath masks reads beyond the stored length.
  always_ff @(posedge clk) begin
    if (we_i && (waddr_i < CNT_W'(MAX_LEN))) begin
      mem_q[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = CHAR_W'(BLANK_CHAR);
    rdata_b_o = CHAR_W'(BLANK_CHAR);
    if (raddr_a_i < CNT_W'(MAX_LEN)) rdata_a_o = mem_q[raddr_a_i[AW-1:0]];
    if (raddr_b_i < CNT_W'(MAX_LEN)) rdata_b_o = mem_q[raddr_b_i[AW-1:0]];
  end

endmodule

// File: rtl/hangman_datapath.sv
// Hangman datapath: stores the secret word, scans it one position per cycle
// per guess, and tracks the reveal mask and remaining-letter count.
module hangman_datapath
  import hangman_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CHAR_W  = DEF_CHAR_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ld,
  input  logic               char_valid,
  input  logic [CHAR_W-1:0]  char_in,
  input  logic               clear,
  input  logic               compare_req,
  input  logic [CHAR_W-1:0]  guess_in,
  output logic               busy,
  output logic               done,
  output logic               match,
  output logic [CNT_W-1:0]   count,
  output logic               repeat_guess,
  output logic [CNT_W-1:0]   wordcount,
  output logic               full,
  output logic [MAX_LEN-1:0] revealed,
  output logic [CNT_W-1:0]   remain,
  output logic               all_revealed,
  input  logic [CNT_W-1:0]   rd_addr,
  output logic [CHAR_W-1:0]  rd_char
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wordcount_q, wordcount_d;
  logic [MAX_LEN-1:0] revealed_q, revealed_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               match_q, match_d;
  logic               repeat_q, repeat_d;
  logic               hit_old_q, hit_old_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CHAR_W-1:0]  guess_q, guess_d;

  logic               we;
  logic [CHAR_W-1:0]  scan_char;
  logic [CHAR_W-1:0]  disp_char;
  logic [MAX_LEN-1:0] idx_bit;
  logic               rev_at_idx;
  logic [CNT_W-1:0]   ones;

  hangman_word_store #(
    .MAX_LEN (MAX_LEN),
    .CHAR_W  (CHAR_W),
    .CNT_W   (CNT_W)
  ) u_store (
    .clk       (clk),
    .we_i      (we),
    .waddr_i   (wordcount_q),
    .wdata_i   (char_in),
    .raddr_a_i (idx_q),
    .rdata_a_o (scan_char),
    .raddr_b_i (rd_addr),
    .rdata_b_o (disp_char)
  );

  assign idx_bit    = MAX_LEN'(1) << idx_q;
  assign rev_at_idx = |(revealed_q & idx_bit);

  always_comb begin
    state_d     = state_q;
    wordcount_d = wordcount_q;
    revealed_d  = revealed_q;
    count_d     = count_q;
    match_d     = match_q;
    repeat_d    = repeat_q;
    hit_old_d   = hit_old_q;
    idx_d       = idx_q;
    guess_d     = guess_q;
    we          = 1'b0;
    // clear outranks everything, including a compare_req in the same cycle.
    if (clear) begin
      state_d     = ST_IDLE;
      wordcount_d = '0;
      revealed_d  = '0;
      count_d     = '0;
      match_d     = 1'b0;
      repeat_d    = 1'b0;
      hit_old_d   = 1'b0;
      idx_d       = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ld && char_valid && !full) begin
            we          = 1'b1;
            wordcount_d = wordcount_q + CNT_W'(1);
          end
          if (compare_req) begin
            guess_d   = guess_in;
            count_d   = '0;
            match_d   = 1'b0;
            repeat_d  = 1'b0;
            hit_old_d = 1'b0;
            idx_d     = '0;
            state_d   = (wordcount_q == '0) ? ST_DONE : ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (scan_char == guess_q) begin
            if (!rev_at_idx) begin
              revealed_d = revealed_q | idx_bit;
              count_d    = count_q + CNT_W'(1);
            end else begin
              hit_old_d = 1'b1;
            end
          end
          // Results are computed from this cycle's updates so the last position counts.
          if (idx_q == wordcount_q - CNT_W'(1)) begin
            state_d  = ST_DONE;
            match_d  = (count_d != '0);
            repeat_d = hit_old_d && (count_d == '0);
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      wordcount_q <= '0;
      revealed_q  <= '0;
      count_q     <= '0;
      match_q     <= 1'b0;
      repeat_q    <= 1'b0;
      hit_old_q   <= 1'b0;
      idx_q       <= '0;
      guess_q     <= '0;
    end else begin
      state_q     <= state_d;
      wordcount_q <= wordcount_d;
      revealed_q  <= revealed_d;
      count_q     <= count_d;
      match_q     <= match_d;
      repeat_q    <= repeat_d;
      hit_old_q   <= hit_old_d;
      idx_q       <= idx_d;
      guess_q     <= guess_d;
    end
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      ones = ones + CNT_W'(revealed_q[i]);
    end
  end

  assign busy         = (state_q == ST_SCAN);
  assign done         = (state_q == ST_DONE);
  assign match        = match_q;
  assign count        = count_q;
  assign repeat_guess = repeat_q;
  assign wordcount    = wordcount_q;
  assign full         = (wordcount_q == CNT_W'(MAX_LEN));
  assign revealed     = revealed_q;
  assign remain       = wordcount_q - ones;
  assign all_revealed = (wordcount_q != '0) && (remain == '0);
  assign rd_char      = (rd_addr < wordcount_q) ? disp_char : CHAR_W'(BLANK_CHAR);

endmodule

// File: tb/tb_hangman_datapath.sv
// Directed bench for hangman_datapath: load, guess latency/results, full word,
// empty compare, and scans aborted by clear and by asynchronous reset.
module tb_hangman_datapath;

  logic        clk;
  logic        resetn;
  logic        ld;
  logic        char_valid;
  logic [7:0]  char_in;
  logic        clear;
  logic        compare_req;
  logic [7:0]  guess_in;
  logic        busy;
  logic        done;
  logic        match;
  logic [4:0]  count;
  logic        repeat_guess;
  logic [4:0]  wordcount;
  logic        full;
  logic [15:0] revealed;
  logic [4:0]  remain;
  logic        all_revealed;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_char;

  int checkCount = 0;
  int failCount  = 0;

  hangman_datapath dut (
    .clk          (clk),
    .resetn       (resetn),
    .ld           (ld),
    .char_valid   (char_valid),
    .char_in      (char_in),
    .clear        (clear),
    .compare_req  (compare_req),
    .guess_in     (guess_in),
    .busy         (busy),
    .done         (done),
    .match        (match),
    .count        (count),
    .repeat_guess (repeat_guess),
    .wordcount    (wordcount),
    .full         (full),
    .revealed     (revealed),
    .remain       (remain),
    .all_revealed (all_revealed),
    .rd_addr      (rd_addr),
    .rd_char      (rd_char)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at a negedge, pass one posedge, drop the strobes.
  task automatic applyStimulus(input logic l, input logic cv, input logic [7:0] c,
                               input logic clr, input logic cmp, input logic [7:0] g);
    ld          = l;
    char_valid  = cv;
    char_in     = c;
    clear       = clr;
    compare_req = cmp;
    guess_in    = g;
    @(negedge clk);
    char_valid  = 1'b0;
    clear       = 1'b0;
    compare_req = 1'b0;
  endtask

  // Issue a guess and check busy for n cycles, then the one-cycle done pulse.
  task automatic runGuess(input logic [7:0] g, input int n);
    int busyBad;
    busyBad = 0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, g);
    for (int k = 1; k <= n; k++) begin
      if (busy !== 1'b1 || done !== 1'b0) busyBad++;
      @(negedge clk);
    end
    checkOutput("busy_window", 32'(busyBad), 0);
    checkOutput("done_pulse", 32'(done), 1);
    checkOutput("busy_in_done", 32'(busy), 0);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 0);
  endtask

  task automatic loadHello();
    logic [7:0] hello [5];
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, hello[i], 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int sawDone;
    resetn = 1'b0; ld = 1'b0; char_valid = 1'b0; char_in = 8'h00;
    clear = 1'b0; compare_req = 1'b0; guess_in = 8'h00; rd_addr = 5'd0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_wordcount", 32'(wordcount), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_revealed", 32'(revealed), 0);
    checkOutput("rst_match", 32'(match), 0);
    checkOutput("rst_rd_char", 32'(rd_char), 0);
    resetn = 1'b1;
    @(negedge clk);

    loadHello();
    checkOutput("hello_wordcount", 32'(wordcount), 5);
    checkOutput("hello_remain", 32'(remain), 5);
    rd_addr = 5'd3; #1;
    checkOutput("rd_char_3", 32'(rd_char), 32'h4C);
    rd_addr = 5'd7; #1;
    checkOutput("rd_char_7", 32'(rd_char), 0);
    applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00);
    checkOutput("ld_low_ignored", 32'(wordcount), 5);

    runGuess(8'h4C, 5);
    checkOutput("L_match", 32'(match), 1);
    checkOutput("L_count", 32'(count), 2);
    checkOutput("L_revealed", 32'(revealed), 32'h000C);
    checkOutput("L_remain", 32'(remain), 3);
    checkOutput("L_repeat", 32'(repeat_guess), 0);

    runGuess(8'h4C, 5);
    checkOutput("L2_match", 32'(match), 0);
    checkOutput("L2_count", 32'(count), 0);
    checkOutput("L2_repeat", 32'(repeat_guess), 1);

    runGuess(8'h5A, 5);
    checkOutput("Z_match", 32'(match), 0);
    checkOutput("Z_count", 32'(count), 0);
    checkOutput("Z_repeat", 32'(repeat_guess), 0);

    runGuess(8'h48, 5);
    checkOutput("H_count", 32'(count), 1);
    runGuess(8'h45, 5);
    checkOutput("E_revealed", 32'(revealed), 32'h000F);
    checkOutput("E_all_revealed", 32'(all_revealed), 0);
    runGuess(8'h4F, 5);
    checkOutput("O_match", 32'(match), 1);
    checkOutput("O_revealed", 32'(revealed), 32'h001F);
    checkOutput("O_remain", 32'(remain), 0);
    checkOutput("O_all_revealed", 32'(all_revealed), 1);

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    checkOutput("clr_wordcount", 32'(wordcount), 0);
    checkOutput("clr_revealed", 32'(revealed), 0);
    checkOutput("clr_match", 32'(match), 0);
    checkOutput("clr_all_revealed", 32'(all_revealed), 0);

    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b1, 8'(8'h41 + i), 1'b0, 1'b0, 8'h00);
    checkOutput("full_wordcount", 32'(wordcount), 16);
    checkOutput("full_flag", 32'(full), 1);
    rd_addr = 5'd15; #1;
    checkOutput("full_rd_15", 32'(rd_char), 32'h50);
    rd_addr = 5'd16; #1;
    checkOutput("full_rd_16", 32'(rd_char), 0);
    runGuess(8'h50, 16);
    checkOutput("full_guess_count", 32'(count), 1);
    checkOutput("full_guess_revealed", 32'(revealed), 32'h8000);
    checkOutput("full_guess_remain", 32'(remain), 15);

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    runGuess(8'h41, 0);
    checkOutput("empty_match", 32'(match), 0);
    checkOutput("empty_count", 32'(count), 0);

    // Same-cycle clear and compare_req: the compare is dropped.
    loadHello();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h48);
    checkOutput("clr_cmp_busy", 32'(busy), 0);
    checkOutput("clr_cmp_done", 32'(done), 0);
    checkOutput("clr_cmp_wordcount", 32'(wordcount), 0);

    loadHello();
    runGuess(8'h48, 5);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h4C);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("abort_busy_before", 32'(busy), 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    checkOutput("abort_wordcount", 32'(wordcount), 0);
    checkOutput("abort_revealed", 32'(revealed), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    sawDone = 0;
    for (int k = 0; k < 8; k++) begin
      if (done === 1'b1) sawDone++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", 32'(sawDone), 0);

    loadHello();
    runGuess(8'h48, 5);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h4C);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("rstab_busy_before", 32'(busy), 1);
    checkOutput("rstab_revealed_before", 32'(revealed), 32'h0001);
    #2 resetn = 1'b0;
    #1;
    checkOutput("rstab_async_busy", 32'(busy), 0);
    checkOutput("rstab_async_wordcount", 32'(wordcount), 0);
    checkOutput("rstab_async_revealed", 32'(revealed), 0);
    @(negedge clk);
    resetn = 1'b1;
    sawDone = 0;
    for (int k = 0; k < 8; k++) begin
      if (done === 1'b1) sawDone++;
      @(negedge clk);
    end
    checkOutput("rstab_no_done", 32'(sawDone), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/hangman_datapath.md
Name: hangman_datapath

Overview:
Datapath partner of the hangman game control FSM. It stores the secret word entered by player 1 and answers each compare request with match/count feedback. It keeps the per-position reveal mask and remaining-letter count, and provides a read port for the display. Sits between keyboard-decoded character strobes, the control FSM (ld/compare/clear) and the VGA/HEX display logic.

Parameters:
MAX_LEN, 16, maximum word length in characters
CHAR_W, 8, character code width (keyboard-decoded ASCII)
CNT_W, 5, width of length/count fields; must satisfy 2^CNT_W > MAX_LEN

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
ld  in  1  level from control: load phase active
char_valid  in  1  one-cycle strobe: char_in holds a new word character
char_in  in  CHAR_W  character to append to the word
clear  in  1  one-cycle pulse: empty word, mask and counters (new round)
compare_req  in  1  one-cycle pulse: start comparing guess_in against the word
guess_in  in  CHAR_W  guessed character, sampled with compare_req
busy  out  1  scan in progress
done  out  1  one-cycle pulse: match/count/repeat valid from this cycle
match  out  1  guess revealed at least one new position
count  out  CNT_W  number of positions newly revealed by last guess
repeat_guess  out  1  last guess exists in word but all its positions were already revealed
wordcount  out  CNT_W  characters currently stored
full  out  1  wordcount == MAX_LEN
revealed  out  MAX_LEN  bit i set = position i revealed
remain  out  CNT_W  wordcount minus popcount(revealed)
all_revealed  out  1  wordcount != 0 and remain == 0
rd_addr  in  CNT_W  display read address
rd_char  out  CHAR_W  word[rd_addr], combinational; 0 when rd_addr >= wordcount

Behaviour:
- Reset (async, resetn=0): state IDLE; wordcount, revealed, count, match, repeat_guess, done, busy all 0; storage contents don't-care but rd_char reads 0.
- States: IDLE, SCAN, DONE. busy=1 in SCAN only. done=1 in DONE only, DONE lasts exactly one cycle, then IDLE.
- Load: in IDLE, ld=1 and char_valid=1 and !full: word[wordcount] <= char_in, wordcount++. char_valid while full, while ld=0, or outside IDLE: ignored, no state change.
- Compare: in IDLE, compare_req=1: latch guess; clear count, match, repeat_guess; idx <= 0.
  - If wordcount == 0, go directly to DONE: match 0, count 0.
  - Otherwise go to SCAN.
- SCAN, one position per cycle at idx:
  - word[idx]==guess and !revealed[idx]: set revealed[idx], count++.
  - word[idx]==guess and revealed[idx]: set internal hit_old flag.
  - At idx == wordcount-1, go to DONE; else idx++.
- Latency for word length N: compare_req sampled at edge 0, SCAN occupies cycles 1..N, done high in cycle N+1. For N=0, done in cycle 1.
- Result update: match = (count != 0) and repeat_guess = (hit_old && count == 0) are registered on entry to DONE and held until the next compare_req. count is held likewise.
- compare_req outside IDLE is ignored; no queuing.
- clear (any state) has highest priority: wordcount, revealed, count, match, repeat_guess reset to 0; state IDLE; an aborted scan produces no done.
- clear and compare_req in the same cycle: clear wins and compare is dropped.
- remain and all_revealed are combinational from wordcount and revealed; they update the cycle after each reveal bit sets.
- Bits of revealed at positions >= wordcount are always 0.

Decomposition:
- hangman_pkg holds:
  - the CHAR_W/MAX_LEN/CNT_W defaults;
  - state encoding localparams S_IDLE=2'd0, S_SCAN=2'd1, S_DONE=2'd2;
  - the BLANK_CHAR constant 8'h00.
- One sub-module, hangman_word_store: MAX_LEN x CHAR_W register file with one write port and two combinational read ports (scan index, display address).
- Popcount for remain stays inline.

Test Plan:
- Load "HELLO" (48,45,4C,4C,4F) with ld=1 -> wordcount=5, remain=5, rd_char(3)=4C, rd_char(7)=00.
- Guess 4C -> busy cycles 1..5, done in cycle 6, match=1, count=2, revealed=5'b01100, remain=3.
- Guess 4C again -> match=0, count=0, repeat_guess=1. Guess 5A -> match=0, count=0, repeat_guess=0.
- Guess 48, 45, 4F -> after the last, revealed=5'b11111, remain=0, all_revealed=1.
- Load 17 characters -> wordcount=16, full=1, 17th ignored. compare_req with empty word (after clear) -> done next cycle, match=0.
- Assert clear at scan cycle 3 -> no done, wordcount=0, revealed=0. Repeat at scan cycle 3 with resetn=0 -> same result, asynchronously.
